// File: rtl/tt_cell_pad_ctrl.sv
// rtl/tt_cell_pad_ctrl.sv - pad-control cell: serial config chain, output register, filtered input events
module tt_cell_pad_ctrl #(
  parameter int NSIG     = 8,
  parameter int FILT_LEN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_sdi,
  input  logic            cfg_en,
  input  logic            cfg_latch,
  output logic            cfg_sdo,
  input  logic [NSIG-1:0] data_out,
  output logic [NSIG-1:0] data_in,
  output logic [NSIG-1:0] evt,
  input  logic [NSIG-1:0] evt_clr,
  output logic            irq,
  input  logic [NSIG-1:0] hsig_Y,
  output logic [NSIG-1:0] hsig_A,
  output logic [NSIG-1:0] hsig_OE,
  output logic [NSIG-1:0] hsig_IE,
  output logic [NSIG-1:0] hsig_SL,
  output logic [NSIG-1:0] hsig_CS,
  output logic [NSIG-1:0] hsig_PD,
  output logic [NSIG-1:0] hsig_PU,
  output logic            hclk_PD,
  output logic            hclk_PU
);

  localparam int L  = 6*NSIG + 2;
  localparam int CW = (FILT_LEN > 0) ? $clog2(FILT_LEN + 1) : 1;

  // Safe power-up config: input enabled with pull-down, output driver off.
  function automatic logic [L-1:0] f_cfg_rst();
    logic [L-1:0] v;
    v = '0;
    for (int i = 0; i < NSIG; i++) begin
      v[6*i+1] = 1'b1;
      v[6*i+4] = 1'b1;
    end
    return v;
  endfunction

  localparam logic [L-1:0] CFG_RST = f_cfg_rst();

  logic [L-1:0]    r_sh;
  logic [L-1:0]    r_cfg;
  logic [NSIG-1:0] r_a;
  logic [NSIG-1:0] r_s1;
  logic [NSIG-1:0] r_s2;
  logic [NSIG-1:0] r_evt;
  logic [NSIG-1:0] w_y;
  logic [NSIG-1:0] w_toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cfg <= CFG_RST;
      r_a   <= '0;
    end else begin
      if (cfg_en)
        r_sh <= {cfg_sdi, r_sh[L-1:1]};
      if (cfg_latch)
        r_cfg <= r_sh;
      r_a <= data_out;
    end
  end

  assign cfg_sdo = r_sh[0];
  assign hsig_A  = r_a;
  assign hclk_PD = r_cfg[L-2];
  assign hclk_PU = r_cfg[L-1];

  for (genvar g = 0; g < NSIG; g++) begin : g_pad
    assign hsig_OE[g] = r_cfg[6*g];
    assign hsig_IE[g] = r_cfg[6*g+1];
    assign hsig_SL[g] = r_cfg[6*g+2];
    assign hsig_CS[g] = r_cfg[6*g+3];
    assign hsig_PD[g] = r_cfg[6*g+4];
    assign hsig_PU[g] = r_cfg[6*g+5];
  end

  assign w_y = hsig_Y & hsig_IE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_y;
      r_s2 <= r_s1;
    end
  end

  if (FILT_LEN == 0) begin : g_nofilt
    assign data_in  = r_s2;
    assign w_toggle = r_s1 ^ r_s2;
  end else begin : g_filt
    logic [NSIG-1:0] r_din;
    logic [CW-1:0]   r_cnt [NSIG];

    always_comb begin
      w_toggle = '0;
      for (int i = 0; i < NSIG; i++)
        w_toggle[i] = (r_s2[i] != r_din[i]) && (r_cnt[i] == CW'(FILT_LEN - 1));
    end

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_din <= '0;
        for (int i = 0; i < NSIG; i++)
          r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < NSIG; i++) begin
          if (w_toggle[i]) begin
            r_din[i] <= ~r_din[i];
            r_cnt[i] <= '0;
          end else if (r_s2[i] != r_din[i]) begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end else begin
            r_cnt[i] <= '0;
          end
        end
      end
    end

    assign data_in = r_din;
  end

  // A new toggle outranks a clear landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_evt <= '0;
    else
      r_evt <= (r_evt & ~evt_clr) | w_toggle;
  end

  assign evt = r_evt;
  assign irq = |r_evt;

endmodule

// File: tb/tb_tt_cell_pad_ctrl.sv
// tb/tb_tt_cell_pad_ctrl.sv - directed self-checking bench for tt_cell_pad_ctrl
module tb_tt_cell_pad_ctrl;

  localparam int NSIG = 8;
  localparam int FILT_LEN = 3;
  localparam int L = 6*NSIG + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_sdi = 1'b0;
  logic            cfg_en = 1'b0;
  logic            cfg_latch = 1'b0;
  logic            cfg_sdo;
  logic [NSIG-1:0] data_out = '0;
  logic [NSIG-1:0] data_in;
  logic [NSIG-1:0] evt;
  logic [NSIG-1:0] evt_clr = '0;
  logic            irq;
  logic [NSIG-1:0] hsig_Y = '0;
  logic [NSIG-1:0] hsig_A;
  logic [NSIG-1:0] hsig_OE, hsig_IE, hsig_SL, hsig_CS, hsig_PD, hsig_PU;
  logic            hclk_PD, hclk_PU;

  int n_vec = 0;
  int n_err = 0;

  tt_cell_pad_ctrl #(.NSIG(NSIG), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst(rst),
    .cfg_sdi(cfg_sdi), .cfg_en(cfg_en), .cfg_latch(cfg_latch), .cfg_sdo(cfg_sdo),
    .data_out(data_out), .data_in(data_in), .evt(evt), .evt_clr(evt_clr), .irq(irq),
    .hsig_Y(hsig_Y), .hsig_A(hsig_A),
    .hsig_OE(hsig_OE), .hsig_IE(hsig_IE), .hsig_SL(hsig_SL),
    .hsig_CS(hsig_CS), .hsig_PD(hsig_PD), .hsig_PU(hsig_PU),
    .hclk_PD(hclk_PD), .hclk_PU(hclk_PU)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [L-1:0] vec);
    for (int j = 0; j < L; j++) begin
      cfg_sdi = vec[j];
      cfg_en  = 1'b1;
      tick();
    end
    cfg_en = 1'b0;
  endtask

  function automatic logic [L-1:0] dflt();
    logic [L-1:0] v;
    v = '0;
    for (int i = 0; i < NSIG; i++) begin
      v[6*i+1] = 1'b1;
      v[6*i+4] = 1'b1;
    end
    return v;
  endfunction

  logic [L-1:0] v_cfg, w_cfg, w2_cfg;
  logic [7:0]   pat;
  logic [57:0]  pbits;

  initial begin
    // Reset asserted asynchronously before the first clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_oe",   hsig_OE, 8'h00);
    chk("rst_ie",   hsig_IE, 8'hFF);
    chk("rst_pd",   hsig_PD, 8'hFF);
    chk("rst_pu",   hsig_PU, 8'h00);
    chk("rst_slcs", {hsig_SL, hsig_CS}, 16'h0000);
    chk("rst_hclk", {hclk_PU, hclk_PD}, 2'b00);
    chk("rst_a",    hsig_A,  8'h00);
    chk("rst_evt",  evt,     8'h00);
    chk("rst_irq",  irq,     1'b0);
    chk("rst_din",  data_in, 8'h00);
    chk("rst_sdo",  cfg_sdo, 1'b0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // Config load: ch3 OE+PU, hclk_PU
    v_cfg = dflt();
    v_cfg[18] = 1'b1;
    v_cfg[23] = 1'b1;
    v_cfg[L-1] = 1'b1;
    shift_in(v_cfg);
    chk("pre_latch_oe", hsig_OE, 8'h00);
    cfg_latch = 1'b1;
    tick();
    cfg_latch = 1'b0;
    chk("ld_oe",   hsig_OE, 8'h08);
    chk("ld_pu",   hsig_PU, 8'h08);
    chk("ld_ie",   hsig_IE, 8'hFF);
    chk("ld_pd",   hsig_PD, 8'hFF);
    chk("ld_hclk", {hclk_PU, hclk_PD}, 2'b10);

    // Shift and latch on the same edge: cfg takes the pre-shift chain
    w_cfg = dflt();
    w_cfg[30] = 1'b1;
    shift_in(w_cfg);
    cfg_sdi = 1'b1;
    cfg_en = 1'b1;
    cfg_latch = 1'b1;
    tick();
    cfg_en = 1'b0;
    cfg_latch = 1'b0;
    chk("sl_oe",   hsig_OE, 8'h20);
    chk("sl_pu",   hsig_PU, 8'h00);
    chk("sl_hclk", {hclk_PU, hclk_PD}, 2'b00);
    chk("sl_sdo",  cfg_sdo, 1'b1);

    // Chain passthrough: pattern 0xA5 repeated, sdo lags sdi by L edges
    pat = 8'hA5;
    for (int k = 0; k < 58; k++) pbits[k] = pat[k % 8];
    for (int j = 1; j <= 58; j++) begin
      cfg_sdi = pbits[j-1];
      cfg_en = 1'b1;
      tick();
      if (j >= L) chk($sformatf("pass_sdo_%0d", j), cfg_sdo, pbits[j-L]);
    end
    cfg_en = 1'b0;
    chk("pass_cfg_hold", hsig_OE, 8'h20);

    // Filter: rising level accepted exactly 2+FILT_LEN edges later
    hsig_Y[0] = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    chk("filt_e4_din", data_in[0], 1'b0);
    chk("filt_e4_irq", irq, 1'b0);
    tick();
    chk("filt_e5_din", data_in, 8'h01);
    chk("filt_e5_evt", evt, 8'h01);
    chk("filt_e5_irq", irq, 1'b1);
    evt_clr[0] = 1'b1;
    tick();
    evt_clr[0] = 1'b0;
    chk("filt_clr_evt", evt, 8'h00);

    // Two-cycle low pulse is discarded
    hsig_Y[0] = 1'b0;
    tick();
    tick();
    hsig_Y[0] = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    chk("pulse_din", data_in, 8'h01);
    chk("pulse_evt", evt, 8'h00);

    // Set beats clear on the same edge, then clear alone wins
    hsig_Y[0] = 1'b0;
    evt_clr[0] = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    chk("ev_e4_din", data_in[0], 1'b1);
    chk("ev_e4_evt", evt, 8'h00);
    tick();
    chk("ev_e5_din", data_in[0], 1'b0);
    chk("ev_setwin", evt, 8'h01);
    chk("ev_setwin_irq", irq, 1'b1);
    tick();
    evt_clr[0] = 1'b0;
    chk("ev_clr", evt, 8'h00);
    chk("ev_clr_irq", irq, 1'b0);

    // Output path: one edge of latency, no combinational path
    data_out = 8'h5A;
    #1;
    chk("out_nocomb", hsig_A, 8'h00);
    tick();
    chk("out_reg", hsig_A, 8'h5A);

    // IE drop on a pad held high filters down to 0 and raises an event
    hsig_Y[2] = 1'b1;
    for (int e = 0; e < 6; e++) tick();
    chk("ie_rise", data_in[2], 1'b1);
    evt_clr = 8'hFF;
    tick();
    evt_clr = '0;
    w2_cfg = w_cfg;
    w2_cfg[13] = 1'b0;
    shift_in(w2_cfg);
    chk("ie_before_latch", data_in[2], 1'b1);
    cfg_latch = 1'b1;
    tick();
    cfg_latch = 1'b0;
    chk("ie_latched", hsig_IE, 8'hFB);
    for (int e = 1; e <= 4; e++) tick();
    chk("ie_e4_din", data_in[2], 1'b1);
    tick();
    chk("ie_e5_din", data_in[2], 1'b0);
    chk("ie_e5_evt", evt, 8'h04);

    // Reset mid-filter and mid-shift returns everything to reset values at once
    hsig_Y[0] = 1'b1;
    cfg_sdi = 1'b1;
    cfg_en = 1'b1;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_din", data_in, 8'h00);
    chk("mrst_evt", evt, 8'h00);
    chk("mrst_ie",  hsig_IE, 8'hFF);
    chk("mrst_oe",  hsig_OE, 8'h00);
    chk("mrst_a",   hsig_A, 8'h00);
    chk("mrst_sdo", cfg_sdo, 1'b0);
    cfg_en = 1'b0;
    tick();
    #2 rst = 1'b0;
    tick();
    chk("post_rst_a", hsig_A, 8'h5A);
    chk("post_rst_din", data_in, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
